// File: rtl/bpu_btb_pkg.sv
// Shared types for the fetch-side branch target buffer.
// Holds the counter encodings, the default table depth and the pending-update record.
// No logic, so there is no latency and no backpressure.
package bpu_btb_pkg;

   localparam int BTB_DEPTH_DEF = 16;
   localparam int PC_W          = 32;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } cnt_t;

   typedef struct packed {
      logic              taken;
      logic              is_jump;
      logic [PC_W-1:2]   target;
   } upd_t;

   function automatic logic [PC_W-1:0] seq_pc(input logic [PC_W-1:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/bpu_sat_cnt2.sv
// Next-state logic for a 2-bit saturating direction counter.
// Purely combinational, so there is zero latency.
// No backpressure; jumps always count as taken.
module bpu_sat_cnt2
   import bpu_btb_pkg::*;
(
   input  cnt_t cnt,
   input  logic taken,
   input  logic is_jump,
   output cnt_t cnt_nxt
);

   always_comb begin
      cnt_nxt = cnt;
      if (taken | is_jump) begin
         case (cnt)
            SNT:     cnt_nxt = WNT;
            WNT:     cnt_nxt = WT;
            default: cnt_nxt = ST;
         endcase
      end else begin
         case (cnt)
            ST:      cnt_nxt = WT;
            WT:      cnt_nxt = WNT;
            default: cnt_nxt = SNT;
         endcase
      end
   end

endmodule

// File: rtl/bpu_btb.sv
// Direct-mapped BTB with a bimodal counter per entry; mispredict detection on EX resolution.
// Lookup and mispredict take 0 cycles; training lands 1 cycle after capture and is forwarded.
// No backpressure. BPU_PERF_CNT_EN adds branch and mispredict event counters.
module bpu_btb
   import bpu_btb_pkg::*;
#(
   parameter  int BTB_DEPTH = BTB_DEPTH_DEF,
   localparam int IDX_W     = $clog2(BTB_DEPTH)
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic [PC_W-1:0]   if_pc,
   input  logic              if_valid,
   output logic              pred_taken,
   output logic [PC_W-1:0]   pred_target,
   input  logic              ex_valid,
   input  logic [PC_W-1:0]   ex_pc,
   input  logic              ex_br,
   input  logic              ex_jump,
   input  logic              ex_taken,
   input  logic [PC_W-1:0]   ex_target,
   input  logic              ex_pred_taken,
   input  logic [PC_W-1:0]   ex_pred_target,
   input  logic              ex_misaligned,
   output logic              mispredict,
   output logic [PC_W-1:0]   redirect_pc,
   input  logic              invalidate
`ifdef BPU_PERF_CNT_EN
  ,output logic [31:0]       perf_branch_cnt,
   output logic [31:0]       perf_mispredict_cnt
`endif
);

   localparam int TAG_W = PC_W - 2 - IDX_W;

   logic [BTB_DEPTH-1:0] tbl_vld;
   logic [TAG_W-1:0]     tbl_tag [BTB_DEPTH];
   logic [PC_W-1:2]      tbl_tgt [BTB_DEPTH];
   logic                 tbl_jmp [BTB_DEPTH];
   cnt_t                 tbl_cnt [BTB_DEPTH];

   logic                 pend_vld;
   logic [IDX_W-1:0]     pend_idx;
   logic [TAG_W-1:0]     pend_tag;
   upd_t                 pend_upd;

   logic                 e_hit;
   logic                 w_en;
   cnt_t                 cnt_seed;
   cnt_t                 w_cnt;
   logic [PC_W-1:2]      w_tgt;

   logic [IDX_W-1:0]     if_idx;
   logic [TAG_W-1:0]     if_tag;
   logic                 fwd;
   logic                 l_vld;
   logic [TAG_W-1:0]     l_tag;
   logic [PC_W-1:2]      l_tgt;
   logic                 l_jmp;
   cnt_t                 l_cnt;
   logic                 hit;

   logic                 mis_raw;
   logic                 cap;
   logic                 unused_bits;

   assign unused_bits = ^if_pc[1:0];

   // The write decision is made when the pending entry lands, so a back-to-back
   // update to the same index naturally sees the previous one already in the table.
   assign e_hit    = tbl_vld[pend_idx] && (tbl_tag[pend_idx] == pend_tag);
   assign w_en     = pend_vld && (e_hit || pend_upd.taken);
   assign cnt_seed = e_hit ? tbl_cnt[pend_idx] : (pend_upd.is_jump ? WT : WNT);
   assign w_tgt    = pend_upd.taken ? pend_upd.target : tbl_tgt[pend_idx];

   bpu_sat_cnt2 u_sat_cnt2 (
      .cnt     (cnt_seed),
      .taken   (pend_upd.taken),
      .is_jump (pend_upd.is_jump),
      .cnt_nxt (w_cnt)
   );

   assign if_idx = if_pc[IDX_W+1:2];
   assign if_tag = if_pc[PC_W-1:IDX_W+2];
   assign fwd    = w_en && (pend_idx == if_idx);

   assign l_vld  = fwd | tbl_vld[if_idx];
   assign l_tag  = fwd ? pend_tag         : tbl_tag[if_idx];
   assign l_tgt  = fwd ? w_tgt            : tbl_tgt[if_idx];
   assign l_jmp  = fwd ? pend_upd.is_jump : tbl_jmp[if_idx];
   assign l_cnt  = fwd ? w_cnt            : tbl_cnt[if_idx];

   assign hit         = if_valid && l_vld && (l_tag == if_tag);
   assign pred_taken  = hit && (l_jmp || (l_cnt inside {WT, ST}));
   assign pred_target = pred_taken ? {l_tgt, 2'b00} : '0;

   assign mis_raw = ex_valid && !ex_misaligned &&
                    ((ex_taken != ex_pred_taken) || (ex_taken && (ex_target != ex_pred_target)));
   assign mispredict  = rst_b && mis_raw;
   assign redirect_pc = mispredict ? (ex_taken ? ex_target : seq_pc(ex_pc)) : '0;

   assign cap = ex_valid && (ex_br || ex_jump) && !ex_misaligned && !invalidate;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         pend_vld <= 1'b0;
         pend_idx <= '0;
         pend_tag <= '0;
         pend_upd <= '0;
      end else begin
         pend_vld <= cap;
         if (cap) begin
            pend_idx         <= ex_pc[IDX_W+1:2];
            pend_tag         <= ex_pc[PC_W-1:IDX_W+2];
            pend_upd.taken   <= ex_taken;
            pend_upd.is_jump <= ex_jump;
            pend_upd.target  <= ex_target[PC_W-1:2];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         tbl_vld <= '0;
      end else if (invalidate) begin
         tbl_vld <= '0;
      end else if (w_en) begin
         tbl_vld[pend_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_en && !invalidate) begin
         tbl_tag[pend_idx] <= pend_tag;
         tbl_tgt[pend_idx] <= w_tgt;
         tbl_jmp[pend_idx] <= pend_upd.is_jump;
         tbl_cnt[pend_idx] <= w_cnt;
      end
   end

`ifdef BPU_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         perf_branch_cnt     <= '0;
         perf_mispredict_cnt <= '0;
      end else begin
         if (cap)        perf_branch_cnt     <= perf_branch_cnt + 32'd1;
         if (mispredict) perf_mispredict_cnt <= perf_mispredict_cnt + 32'd1;
      end
   end
`else
   // Event counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_bpu_btb.sv
// Directed and randomized bench for bpu_btb against a table-of-entries reference model.
module tb_bpu_btb;

   logic        clk = 1'b0;
   logic        rst_b;
   logic [31:0] if_pc;
   logic        if_valid;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_br;
   logic        ex_jump;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        ex_misaligned;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic        invalidate;
`ifdef BPU_PERF_CNT_EN
   logic [31:0] perf_branch_cnt;
   logic [31:0] perf_mispredict_cnt;
   int unsigned m_br = 0;
   int unsigned m_mp = 0;
`endif

   always #5 clk = ~clk;

   bpu_btb dut (
      .clk            (clk),
      .rst_b          (rst_b),
      .if_pc          (if_pc),
      .if_valid       (if_valid),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .ex_valid       (ex_valid),
      .ex_pc          (ex_pc),
      .ex_br          (ex_br),
      .ex_jump        (ex_jump),
      .ex_taken       (ex_taken),
      .ex_target      (ex_target),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .ex_misaligned  (ex_misaligned),
      .mispredict     (mispredict),
      .redirect_pc    (redirect_pc),
      .invalidate     (invalidate)
`ifdef BPU_PERF_CNT_EN
     ,.perf_branch_cnt     (perf_branch_cnt),
      .perf_mispredict_cnt (perf_mispredict_cnt)
`endif
   );

   typedef struct {
      bit          v;
      int unsigned tag;
      logic [31:0] tgt;
      bit          j;
      int          c;
   } ent_t;

   ent_t        m [16];
   bit          p_vld = 1'b0;
   logic [31:0] p_pc, p_tgt;
   bit          p_taken, p_jmp;

   int errors = 0;
   int checks = 0;

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % 32'd16);
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] pc);
      return pc / 32'd64;
   endfunction

   function automatic ent_t upd(input ent_t e, input logic [31:0] pc, input bit tk,
                                input logic [31:0] tg, input bit jp);
      ent_t r;
      r = e;
      if (e.v && e.tag == tag_of(pc)) begin
         r.c = tk ? ((e.c < 3) ? e.c + 1 : 3) : ((e.c > 0) ? e.c - 1 : 0);
         if (tk) r.tgt = tg;
         r.j = jp;
      end else if (tk) begin
         r.v = 1'b1; r.tag = tag_of(pc); r.tgt = tg; r.j = jp; r.c = jp ? 3 : 2;
      end
      return r;
   endfunction

   function automatic ent_t view(input int i);
      ent_t e;
      e = m[i];
      if (p_vld && idx_of(p_pc) == i) e = upd(e, p_pc, p_taken, p_tgt, p_jmp);
      return e;
   endfunction

   function automatic bit exp_mp();
      return ex_valid && !ex_misaligned &&
             ((ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      ent_t e;
      bit hit, pt, mp;
      logic [31:0] ptg, rd;
      e   = view(idx_of(if_pc));
      hit = if_valid && e.v && (e.tag == tag_of(if_pc));
      pt  = hit && (e.j || e.c >= 2);
      ptg = pt ? (e.tgt & 32'hFFFF_FFFC) : 32'h0;
      mp  = exp_mp();
      rd  = mp ? (ex_taken ? ex_target : ex_pc + 32'd4) : 32'h0;
      chk("pred_taken",  {31'b0, pred_taken}, {31'b0, pt});
      chk("pred_target", pred_target, ptg);
      chk("mispredict",  {31'b0, mispredict}, {31'b0, mp});
      chk("redirect_pc", redirect_pc, rd);
   endtask

   task automatic commit();
      bit cap;
      cap = ex_valid && (ex_br || ex_jump) && !ex_misaligned && !invalidate;
`ifdef BPU_PERF_CNT_EN
      if (cap) m_br++;
      if (exp_mp()) m_mp++;
`endif
      if (invalidate) begin
         for (int i = 0; i < 16; i++) m[i].v = 1'b0;
         p_vld = 1'b0;
      end else begin
         if (p_vld) m[idx_of(p_pc)] = upd(m[idx_of(p_pc)], p_pc, p_taken, p_tgt, p_jmp);
         p_vld = cap; p_pc = ex_pc; p_taken = ex_taken; p_tgt = ex_target; p_jmp = ex_jump;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m[i].v = 1'b0;
      p_vld = 1'b0;
`ifdef BPU_PERF_CNT_EN
      m_br = 0; m_mp = 0;
`endif
   endtask

   task automatic cycle();
      @(negedge clk);
      check_model();
      @(posedge clk);
      commit();
      #1;
   endtask

   task automatic set_if(input bit v, input logic [31:0] pc);
      if_valid = v; if_pc = pc;
   endtask

   task automatic set_ex(input bit v, input bit br, input bit jp, input bit tk,
                         input logic [31:0] pc, input logic [31:0] tg,
                         input bit ptk, input logic [31:0] ptg, input bit mis);
      ex_valid = v; ex_br = br; ex_jump = jp; ex_taken = tk; ex_pc = pc; ex_target = tg;
      ex_pred_taken = ptk; ex_pred_target = ptg; ex_misaligned = mis;
   endtask

   task automatic idle_ex();
      set_ex(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
   endtask

   task automatic lit_pred(input string tag, input bit pt, input logic [31:0] ptg);
      #1;
      chk({tag, "_taken"},  {31'b0, pred_taken}, {31'b0, pt});
      chk({tag, "_target"}, pred_target, ptg);
   endtask

   task automatic lit_mis(input string tag, input bit mp, input logic [31:0] rd);
      #1;
      chk({tag, "_mispredict"}, {31'b0, mispredict}, {31'b0, mp});
      chk({tag, "_redirect"},   redirect_pc, rd);
   endtask

   logic [31:0] pc_pool  [8] = '{32'h100, 32'h140, 32'h180, 32'h200, 32'h1100, 32'h104, 32'h3c0, 32'h2000};
   logic [31:0] tgt_pool [4] = '{32'h40, 32'h180, 32'h8000, 32'h1234_5678};

   initial begin
      rst_b = 1'b0; invalidate = 1'b0;
      idle_ex();
      set_if(1, 32'h100);
      #2;
      chk("rst_pred_taken",  {31'b0, pred_taken}, 32'h0);
      chk("rst_pred_target", pred_target, 32'h0);
      chk("rst_mispredict",  {31'b0, mispredict}, 32'h0);
      chk("rst_redirect",    redirect_pc, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_b = 1'b1;

      set_if(1, 32'h100);
      lit_pred("cold_lookup", 0, 32'h0);
      cycle();

      set_ex(1, 1, 0, 1, 32'h100, 32'h180, 0, 32'h0, 0);
      lit_mis("first_taken", 1, 32'h180);
      cycle();
      idle_ex();
      cycle();
      lit_pred("trained_wt", 1, 32'h180);
      cycle();

      set_ex(1, 1, 0, 0, 32'h100, 32'h180, 1, 32'h180, 0);
      lit_mis("nt_redirect", 1, 32'h104);
      cycle();
      cycle();
      idle_ex();
      cycle();
      lit_pred("after_two_nt", 0, 32'h0);
      cycle();
      set_ex(1, 1, 0, 0, 32'h100, 32'h180, 0, 32'h0, 0);
      lit_mis("nt_correct", 0, 32'h0);
      cycle();
      set_ex(1, 1, 0, 1, 32'h100, 32'h180, 0, 32'h0, 0);
      cycle();
      idle_ex();
      cycle();
      lit_pred("sat_at_snt", 0, 32'h0);
      cycle();

      set_ex(1, 0, 1, 1, 32'h200, 32'h40, 0, 32'h0, 0);
      cycle();
      idle_ex();
      set_if(1, 32'h200);
      lit_pred("jal_forward", 1, 32'h40);
      cycle();

      set_if(1, 32'h140);
      lit_pred("alias_miss", 0, 32'h0);
      cycle();

      set_ex(1, 1, 0, 1, 32'h300, 32'h302, 0, 32'h0, 1);
      lit_mis("misaligned", 0, 32'h0);
      cycle();
      idle_ex();
      cycle();
      set_if(1, 32'h300);
      lit_pred("misaligned_nowrite", 0, 32'h0);
      cycle();

      set_ex(1, 1, 0, 1, 32'h400, 32'h480, 0, 32'h0, 0);
      invalidate = 1'b1;
      cycle();
      invalidate = 1'b0;
      idle_ex();
      foreach (pc_pool[i]) begin
         set_if(1, pc_pool[i]);
         lit_pred("post_invalidate", 0, 32'h0);
         cycle();
      end
      set_if(1, 32'h400);
      lit_pred("inval_wins_capture", 0, 32'h0);
      cycle();

      set_ex(1, 1, 0, 1, 32'h500, 32'h580, 0, 32'h0, 0);
      cycle();
      idle_ex();
      set_if(1, 32'h500);
      @(negedge clk);
      rst_b = 1'b0;
      model_reset();
      #1;
      chk("midrst_pred_taken", {31'b0, pred_taken}, 32'h0);
      @(posedge clk);
      #1 rst_b = 1'b1;
      lit_pred("midrst_dropped", 0, 32'h0);
      cycle();
      cycle();

      for (int n = 0; n < 600; n++) begin
         int kind;
         bit tk;
         set_if($urandom_range(3) != 0, pc_pool[$urandom_range(7)]);
         kind = $urandom_range(3);
         tk   = (kind == 2) ? 1'b1 : 1'($urandom_range(1));
         set_ex($urandom_range(2) != 0, kind == 1, kind == 2, tk,
                pc_pool[$urandom_range(7)], tgt_pool[$urandom_range(3)],
                1'($urandom_range(1)), tgt_pool[$urandom_range(3)],
                $urandom_range(9) == 0);
         invalidate = ($urandom_range(49) == 0);
         cycle();
      end
      invalidate = 1'b0;
      idle_ex();

`ifdef BPU_PERF_CNT_EN
      #1;
      chk("perf_branch_cnt",     perf_branch_cnt,     m_br);
      chk("perf_mispredict_cnt", perf_mispredict_cnt, m_mp);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
